// File: rtl/ahb_node_pipe.sv
// AHB-Lite decoder/mux for one master and NB_SLAVES slaves. The address map is set at runtime, and a built-in default slave returns ERROR.
// A registered data-phase select steers the responses. Mapped slaves add no wait states; unmapped NONSEQ/SEQ accesses cost 1 wait + 1 ERROR cycle.
module ahb_node_pipe #(
    parameter int NB_SLAVES      = 8,
    parameter int AHB_DATA_WIDTH = 32,
    parameter int AHB_ADDR_WIDTH = 32,
    parameter int USE_HSEL       = 0,
    parameter int ERR_CNT_W      = 8
) (
    input  logic                                          hclk,
    input  logic                                          hresetn,
    // master side
    input  logic [AHB_ADDR_WIDTH-1:0]                     hadrr_i,
    input  logic [AHB_DATA_WIDTH-1:0]                     hwdata_i,
    input  logic                                          hsel_i,
    input  logic                                          hwrite_i,
    input  logic                                          hmastlock_i,
    input  logic [1:0]                                    htrans_i,
    input  logic [3:0]                                    hprot_i,
    input  logic [2:0]                                    hburst_i,
    input  logic [2:0]                                    hsize_i,
    output logic                                          hresp_o,
    output logic                                          hreadyout_o,
    output logic [AHB_DATA_WIDTH-1:0]                     hrdata_o,
    // slave side
    output logic [NB_SLAVES-1:0][AHB_ADDR_WIDTH-1:0]      hadrr_o,
    output logic [NB_SLAVES-1:0][AHB_DATA_WIDTH-1:0]      hwdata_o,
    output logic [NB_SLAVES-1:0]                          hsel_o,
    output logic [NB_SLAVES-1:0]                          hwrite_o,
    output logic [NB_SLAVES-1:0]                          hmastlock_o,
    output logic [NB_SLAVES-1:0][1:0]                     htrans_o,
    output logic [NB_SLAVES-1:0][3:0]                     hprot_o,
    output logic [NB_SLAVES-1:0][2:0]                     hburst_o,
    output logic [NB_SLAVES-1:0][2:0]                     hsize_o,
    output logic [NB_SLAVES-1:0]                          hready_o,
    input  logic [NB_SLAVES-1:0]                          hresp_i,
    input  logic [NB_SLAVES-1:0]                          hreadyout_i,
    input  logic [NB_SLAVES-1:0][AHB_DATA_WIDTH-1:0]      hrdata_i,
    // address map
    input  logic [NB_SLAVES-1:0][AHB_ADDR_WIDTH-1:0]      START_ADDR_i,
    input  logic [NB_SLAVES-1:0][AHB_ADDR_WIDTH-1:0]      END_ADDR_i,
    // unmapped-access log
    output logic [ERR_CNT_W-1:0]                          err_cnt_o,
    output logic [AHB_ADDR_WIDTH-1:0]                     err_addr_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ERR1 = 2'd1,
        S_ERR2 = 2'd2
    } state_e;

    logic                       qual;
    logic [NB_SLAVES-1:0]       match;
    logic [NB_SLAVES-1:0]       sel;
    logic                       hit;
    logic                       dflt;
    logic                       err_start;
    logic [NB_SLAVES:0]         dsel_q;
    state_e                     state_q;
    logic                       dflt_rdy_q;
    logic                       dflt_resp_q;
    logic [ERR_CNT_W-1:0]       err_cnt_q;
    logic [AHB_ADDR_WIDTH-1:0]  err_addr_q;

    assign qual = (USE_HSEL == 0) ? 1'b1 : hsel_i;

    // Overlapping regions resolve to the lowest index, which keeps hsel_o one-hot or zero
    always_comb begin
        match = '0;
        sel   = '0;
        hit   = 1'b0;
        for (int i = 0; i < NB_SLAVES; i++) begin
            match[i] = qual && (hadrr_i >= START_ADDR_i[i]) && (hadrr_i <= END_ADDR_i[i]);
            if (match[i] && !hit) begin
                sel[i] = 1'b1;
                hit    = 1'b1;
            end
        end
    end

    assign dflt      = qual & ~hit;
    assign hsel_o    = sel;
    assign hready_o  = {NB_SLAVES{hreadyout_o}};
    assign err_start = hreadyout_o & dflt & htrans_i[1];

    always_comb begin
        for (int i = 0; i < NB_SLAVES; i++) begin
            hadrr_o[i]     = hadrr_i;
            hwdata_o[i]    = hwdata_i;
            hwrite_o[i]    = hwrite_i;
            hmastlock_o[i] = hmastlock_i;
            htrans_o[i]    = htrans_i;
            hprot_o[i]     = hprot_i;
            hburst_o[i]    = hburst_i;
            hsize_o[i]     = hsize_i;
        end
    end

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            dsel_q <= '0;
        end else if (hreadyout_o) begin
            dsel_q <= {dflt, sel};
        end
    end

    // Responses come from the slave that owned the previous address phase
    always_comb begin
        hrdata_o    = '0;
        hresp_o     = 1'b0;
        hreadyout_o = 1'b1;
        if (dsel_q[NB_SLAVES]) begin
            hresp_o     = dflt_resp_q;
            hreadyout_o = dflt_rdy_q;
        end
        for (int i = 0; i < NB_SLAVES; i++) begin
            if (dsel_q[i]) begin
                hrdata_o    = hrdata_i[i];
                hresp_o     = hresp_i[i];
                hreadyout_o = hreadyout_i[i];
            end
        end
    end

    // Default slave: the two-cycle ERROR response, with the log updated on each entry to ERR1
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q     <= S_IDLE;
            dflt_rdy_q  <= 1'b1;
            dflt_resp_q <= 1'b0;
            err_cnt_q   <= '0;
            err_addr_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE, S_ERR2: begin
                    if (err_start) begin
                        state_q     <= S_ERR1;
                        dflt_rdy_q  <= 1'b0;
                        dflt_resp_q <= 1'b1;
                        err_addr_q  <= hadrr_i;
                        if (!(&err_cnt_q)) begin
                            err_cnt_q <= err_cnt_q + {{(ERR_CNT_W-1){1'b0}}, 1'b1};
                        end
                    end else begin
                        state_q     <= S_IDLE;
                        dflt_rdy_q  <= 1'b1;
                        dflt_resp_q <= 1'b0;
                    end
                end
                S_ERR1: begin
                    state_q     <= S_ERR2;
                    dflt_rdy_q  <= 1'b1;
                    dflt_resp_q <= 1'b1;
                end
                default: begin
                    state_q     <= S_IDLE;
                    dflt_rdy_q  <= 1'b1;
                    dflt_resp_q <= 1'b0;
                end
            endcase
        end
    end

    assign err_cnt_o  = err_cnt_q;
    assign err_addr_o = err_addr_q;

endmodule
